csel_subtractor_pipe: RTL and testbench

CSEL_SUBTRACTOR_PIPE -- requirements
Module: csel_subtractor_pipe

---
 rtl/csel_subtractor_pipe_pkg.sv | 49 ++++
 rtl/csel_subtractor_pipe_half_adder_pair.sv | 33 +++
 rtl/csel_subtractor_pipe.sv | 109 ++++++++++
 tb/tb_csel_subtractor_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/csel_subtractor_pipe_pkg.sv
// Shared types and the flag helper for the two-stage carry-select subtractor.
// Records are sized for the widest supported operand; narrower instances use the low bits.
package csel_subtractor_pipe_pkg;

    localparam int CSEL_WIDTH_DEFAULT = 32;
    localparam int CSEL_MAX_WIDTH     = 64;
    localparam int CSEL_MAX_HALF      = CSEL_MAX_WIDTH / 2;

    typedef logic [CSEL_MAX_HALF-1:0]  half_t;
    typedef logic [CSEL_MAX_WIDTH-1:0] word_t;

    typedef struct packed {
        half_t lo_sum;
        logic  lo_c;
        half_t hi_sum0;
        logic  hi_c0;
        logic  hi_cm0;
        half_t hi_sum1;
        logic  hi_c1;
        logic  hi_cm1;
        logic  valid;
    } s1_t;

    typedef struct packed {
        logic bout;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    typedef struct packed {
        word_t  d;
        flags_t flags;
        logic   valid;
    } s2_t;

    // With D = A + ~B + ~bin, the carry out is the inverse of the borrow, and
    // signed overflow is the disagreement between the carries into and out of the MSB.
    function automatic flags_t csel_flags(input logic cout, input logic c_msb,
                                          input logic d_msb, input logic d_zero);
        flags_t f;
        f.bout     = ~cout;
        f.overflow = cout ^ c_msb;
        f.zero     = d_zero;
        f.negative = d_msb;
        return f;
    endfunction

endpackage

// File: rtl/csel_subtractor_pipe_half_adder_pair.sv
// Combinational ripple adder over one half word producing both carry-in
// variants, each with {carry out, carry into the top bit}.
module csel_half_adder_pair #(
    parameter int HW = 16
) (
    input  logic [HW-1:0] a_i,
    input  logic [HW-1:0] b_i,
    output logic [HW-1:0] sum0_o,
    output logic [HW-1:0] sum1_o,
    output logic [1:0]    carry0_o,
    output logic [1:0]    carry1_o
);

    always_comb begin
        logic [HW:0] c0;
        logic [HW:0] c1;
        c0       = '0;
        c1       = '0;
        sum0_o   = '0;
        sum1_o   = '0;
        c0[0]    = 1'b0;
        c1[0]    = 1'b1;
        for (int i = 0; i < HW; i++) begin
            sum0_o[i] = a_i[i] ^ b_i[i] ^ c0[i];
            sum1_o[i] = a_i[i] ^ b_i[i] ^ c1[i];
            c0[i+1]   = (a_i[i] & b_i[i]) | (c0[i] & (a_i[i] ^ b_i[i]));
            c1[i+1]   = (a_i[i] & b_i[i]) | (c1[i] & (a_i[i] ^ b_i[i]));
        end
        carry0_o = {c0[HW], c0[HW-1]};
        carry1_o = {c1[HW], c1[HW-1]};
    end

endmodule

// File: rtl/csel_subtractor_pipe.sv
// Two-stage carry-select subtractor D = A - B - bin with valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module csel_subtractor_pipe
    import csel_subtractor_pipe_pkg::*;
#(
    parameter int WIDTH = CSEL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int HALF = WIDTH / 2;

    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;

    logic [WIDTH-1:0] b_n;
    logic [HALF-1:0]  lo_sum0, lo_sum1, hi_sum0, hi_sum1;
    logic [1:0]       lo_c0, lo_c1, hi_c0, hi_c1;
    logic             s2_ready;
    logic [HALF-1:0]  hi_sel;
    logic             hi_cout_sel, hi_cmsb_sel;
    logic [WIDTH-1:0] diff;

    assign b_n = ~B;

    csel_half_adder_pair #(.HW(HALF)) u_lo (
        .a_i      (A[HALF-1:0]),
        .b_i      (b_n[HALF-1:0]),
        .sum0_o   (lo_sum0),
        .sum1_o   (lo_sum1),
        .carry0_o (lo_c0),
        .carry1_o (lo_c1)
    );

    csel_half_adder_pair #(.HW(HALF)) u_hi (
        .a_i      (A[WIDTH-1:HALF]),
        .b_i      (b_n[WIDTH-1:HALF]),
        .sum0_o   (hi_sum0),
        .sum1_o   (hi_sum1),
        .carry0_o (hi_c0),
        .carry1_o (hi_c1)
    );

    always_comb begin
        s2_ready    = ~s2_q.valid | out_ready;
        in_ready    = ~s1_q.valid | s2_ready;

        hi_sel      = s1_q.lo_c ? s1_q.hi_sum1[HALF-1:0] : s1_q.hi_sum0[HALF-1:0];
        hi_cout_sel = s1_q.lo_c ? s1_q.hi_c1 : s1_q.hi_c0;
        hi_cmsb_sel = s1_q.lo_c ? s1_q.hi_cm1 : s1_q.hi_cm0;
        diff        = {hi_sel, s1_q.lo_sum[HALF-1:0]};

        s1_d = s1_q;
        if (in_ready) begin
            s1_d.valid = in_valid;
            if (in_valid) begin
                // Lower half carry-in is ~bin, so bin=1 picks the carry-0 result.
                s1_d.lo_sum  = half_t'(bin ? lo_sum0 : lo_sum1);
                s1_d.lo_c    = bin ? lo_c0[1] : lo_c1[1];
                s1_d.hi_sum0 = half_t'(hi_sum0);
                s1_d.hi_c0   = hi_c0[1];
                s1_d.hi_cm0  = hi_c0[0];
                s1_d.hi_sum1 = half_t'(hi_sum1);
                s1_d.hi_c1   = hi_c1[1];
                s1_d.hi_cm1  = hi_c1[0];
            end
        end

        s2_d = s2_q;
        if (s2_ready) begin
            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d.d     = word_t'(diff);
                s2_d.flags = csel_flags(hi_cout_sel, hi_cmsb_sel, diff[WIDTH-1], diff == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign out_valid = s2_q.valid;
    assign D         = s2_q.d[WIDTH-1:0];
    assign bout      = s2_q.flags.bout;
    assign overflow  = s2_q.flags.overflow;
    assign zero      = s2_q.flags.zero;
    assign negative  = s2_q.flags.negative;

endmodule

// File: tb/tb_csel_subtractor_pipe.sv
// Bench for csel_subtractor_pipe: directed vectors, backpressure, mid-flight reset,
// and randomized traffic scored against an arithmetic reference model.
module tb_csel_subtractor_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, bin;
    logic         out_valid, out_ready;
    logic         bout, overflow, zero, negative;
    logic [W-1:0] A, B, D;
    logic [W+3:0] obs;

    int n_vec  = 0;
    int n_fail = 0;
    int n_out  = 0;

    logic [W+3:0] exp_q[$];
    logic         hold_pending = 1'b0;
    logic [W+3:0] held = '0;

    always #5 clk = ~clk;

    csel_subtractor_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .bout      (bout),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    assign obs = {D, bout, overflow, zero, negative};

    function automatic logic [W+3:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic bi);
        longint unsigned av, bv;
        logic [W-1:0]    d;
        logic            bo, ov;
        av = 64'(a);
        bv = 64'(b) + 64'(bi);
        d  = W'(av - bv);
        bo = av < bv;
        ov = (a[W-1] ^ b[W-1]) & (d[W-1] ^ a[W-1]);
        return {d, bo, ov, (d == '0), d[W-1]};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0 ] o, input logic [63:0] e);
        n_vec++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Scoreboard and output-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_pending <= 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(obs), 64'(held));
            end
            if (out_valid && out_ready) begin
                check("out_has_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("result", 64'(obs), 64'(exp_q.pop_front()));
                n_out <= n_out + 1;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_model(A, B, bin));
            hold_pending <= out_valid && !out_ready;
            held         <= obs;
        end
    end

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic bi, input logic [W+3:0] e);
        @(posedge clk); #1;
        A = a; B = b; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check(tag, 64'(obs), 64'(e));
    endtask

    initial begin
        logic [W-1:0] va[5];
        logic [W-1:0] vb[5];
        int           idx, accepted, cycles, n0;
        logic         acc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs", 64'(obs), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        directed("basic", 32'h0000000A, 32'h00000003, 1'b0, {32'h00000007, 4'b0000});
        directed("borrow_wrap", 32'h00000000, 32'h00000001, 1'b1, {32'hFFFFFFFE, 4'b1001});
        directed("signed_ovf", 32'h80000000, 32'h00000001, 1'b0, {32'h7FFFFFFF, 4'b0100});
        directed("zero", 32'h12345678, 32'h12345678, 1'b0, {32'h00000000, 4'b0010});

        // Backpressure: five offered back-to-back with the consumer stalled.
        for (int i = 0; i < 5; i++) begin
            va[i] = W'($urandom);
            vb[i] = W'($urandom);
        end
        @(posedge clk); #1;
        idx = 0; out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 5);
            A = va[idx % 5]; B = vb[idx % 5]; bin = idx[0];
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("bp_accepts", 64'(idx), 64'd2);
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n0 = n_out;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 5);
            A = va[idx % 5]; B = vb[idx % 5]; bin = idx[0];
            @(negedge clk);
            check("bp_drain_rate", 64'(out_valid), 64'd1);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 64'(idx), 64'd5);
        check("bp_all_delivered", 64'(n_out - n0), 64'd5);
        @(negedge clk);
        check("bp_empty", 64'(out_valid), 64'd0);

        // Reset with both stages full and an input offered during reset.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        A = W'($urandom); B = W'($urandom); bin = 1'b0;
        @(posedge clk); #1;
        A = W'($urandom); B = W'($urandom); bin = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b1; A = W'($urandom);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'(obs), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_no_leftover", 64'(out_valid), 64'd0);
        end

        // Randomized traffic with random backpressure.
        @(posedge clk); #1;
        accepted = 0; cycles = 0; acc = 1'b0; in_valid = 1'b0;
        while (accepted < 10000 && cycles < 60000) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                A = pick_operand(); B = pick_operand(); bin = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) accepted++;
            @(posedge clk); #1;
            cycles++;
        end
        check("random_accept_budget", 64'(accepted >= 10000), 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_out_valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
